// File: rtl/xalu_pkg.sv
// Shared definitions for the XALU multiply/divide sequencer: opcode encodings,
// FSM state encoding and the helper that sizes the latency counter.
// Optional feature macro: XALU_MADD_EN (enables the madd/msub family, opcodes 6-9).
package xalu_pkg;

    localparam int XALUOP_W = 4;

    localparam logic [XALUOP_W-1:0] OP_MULT  = 4'd0;
    localparam logic [XALUOP_W-1:0] OP_MULTU = 4'd1;
    localparam logic [XALUOP_W-1:0] OP_DIV   = 4'd2;
    localparam logic [XALUOP_W-1:0] OP_DIVU  = 4'd3;
    localparam logic [XALUOP_W-1:0] OP_MTHI  = 4'd4;
    localparam logic [XALUOP_W-1:0] OP_MTLO  = 4'd5;
    localparam logic [XALUOP_W-1:0] OP_MADD  = 4'd6;
    localparam logic [XALUOP_W-1:0] OP_MADDU = 4'd7;
    localparam logic [XALUOP_W-1:0] OP_MSUB  = 4'd8;
    localparam logic [XALUOP_W-1:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } xalu_state_t;

    // Counter must hold the larger of the two latencies.
    function automatic int xalu_cnt_w(input int mult_lat, input int div_lat);
        int mx;
        mx = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/xalu_countdown.sv
// Loadable down-counter that tracks the remaining busy cycles of an XALU op.
// Latency: state updates on the rising edge; zero_o is combinational from this cycle's controls.
// No backpressure: clear has priority over load, counting stops at zero.
module xalu_countdown
    import xalu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         clear_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear beats load, otherwise decrement until zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // zero_o means the counter is zero after the coming edge, so the owner can
    // act on the very edge where the count reaches zero.
    assign zero_o = (count_d == '0);

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/xalu_sequencer.sv
// Multi-cycle sequencer for the E-stage mult/div unit; owns architectural HI/LO.
// Latency: busy high for MULT_LAT/DIV_LAT cycles after the start edge, HI/LO commit on the last.
// Backpressure: busy stalls the pipe; start while busy is illegal, cancel aborts with no commit.
// Optional feature macro: XALU_MADD_EN (madd/maddu/msub/msubu accumulate into HI/LO).
module xalu_sequencer
    import xalu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [XALUOP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic                cancel,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int CNT_W = xalu_cnt_w(MULT_LAT, DIV_LAT);

    xalu_state_t state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] ph_q, ph_d, pl_q, pl_d;

    logic             cnt_load, cnt_clear, cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    logic [63:0] prod_s, prod_u, res;
    logic [31:0] quo, rem;
    logic        is_seq_op;
    logic        is_div_op;

    // Result arithmetic for the op presented with start; divide by zero keeps HI/LO.
    always_comb begin
        prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u    = {32'd0, a} * {32'd0, b};
        quo       = 32'($signed(a) / $signed(b));
        rem       = 32'($signed(a) % $signed(b));
        res       = {hi_q, lo_q};
        is_seq_op = 1'b0;
        is_div_op = 1'b0;
        // The one signed overflow case is pinned explicitly.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end
        case (op)
            OP_MULT:  begin is_seq_op = 1'b1; res = prod_s; end
            OP_MULTU: begin is_seq_op = 1'b1; res = prod_u; end
            OP_DIV: begin
                is_seq_op = 1'b1;
                is_div_op = 1'b1;
                if (b != 32'd0) res = {rem, quo};
            end
            OP_DIVU: begin
                is_seq_op = 1'b1;
                is_div_op = 1'b1;
                if (b != 32'd0) res = {a % b, a / b};
            end
`ifdef XALU_MADD_EN
            OP_MADD:  begin is_seq_op = 1'b1; res = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin is_seq_op = 1'b1; res = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin is_seq_op = 1'b1; res = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin is_seq_op = 1'b1; res = {hi_q, lo_q} - prod_u; end
`endif
            default: ;
        endcase
    end

    // FSM next state, pending result, HI/LO update and counter control.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ph_d      = ph_q;
        pl_d      = pl_q;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_value = '0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_seq_op) begin
                        ph_d      = res[63:32];
                        pl_d      = res[31:0];
                        cnt_load  = 1'b1;
                        cnt_value = is_div_op ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state_d   = BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            BUSY: begin
                if (cancel) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_zero) begin
                    hi_d    = ph_q;
                    lo_d    = pl_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    xalu_countdown #(.W(CNT_W)) u_countdown (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .clear_i (cnt_clear),
        .zero_o  (cnt_zero)
    );

    // State, pending result and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
        end
    end

    // The stall logic must never present a live start while an op is in flight.
    a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
        !(start && !cancel && state_q == BUSY));

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_xalu_sequencer.sv
module tb_xalu_sequencer;
    import xalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;
    int cyc;

    xalu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // 1: signed mult -1 * 2
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        count_busy(cyc);
        check("mult_lat", cyc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        // 2: div -7/2 then divu
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(cyc);
        check("div_lat", cyc, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
        count_busy(cyc);
        check("divu_lat", cyc, 32'd10);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'd1);

        // signed overflow boundary
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(cyc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // 3: mthi/mtlo then divide by zero
        issue(OP_MTHI, 32'h11, 32'd0);
        check("mthi_nobusy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        issue(OP_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);
        issue(OP_DIV, 32'd5, 32'd0);
        count_busy(cyc);
        check("div0_lat", cyc, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // 4: multu cancelled on busy cycle 3
        issue(OP_MULTU, 32'd3, 32'd4);
        check("cancel_busy1", {31'd0, busy}, 32'd1);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy_drop", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        check("cancel_hi", hi, 32'h11);
        check("cancel_lo", lo, 32'h22);

        // start together with cancel is dropped
        cancel = 1'b1;
        issue(OP_MULT, 32'd7, 32'd7);
        cancel = 1'b0;
        check("startcancel_busy", {31'd0, busy}, 32'd0);
        tick();
        check("startcancel_busy2", {31'd0, busy}, 32'd0);
        check("startcancel_lo", lo, 32'h22);

        // cancel on the commit edge suppresses the commit
        issue(OP_MULT, 32'd6, 32'd6);
        repeat (4) tick();
        check("commitcancel_busy5", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("commitcancel_busy", {31'd0, busy}, 32'd0);
        check("commitcancel_lo", lo, 32'h22);

        // 5: reset mid-div on busy cycle 6, then a new mult
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (5) tick();
        check("rstdiv_busy6", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstdiv_busy", {31'd0, busy}, 32'd0);
        check("rstdiv_hi", hi, 32'd0);
        check("rstdiv_lo", lo, 32'd0);
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
        count_busy(cyc);
        check("postrst_lat", cyc, 32'd5);
        check("postrst_hi", hi, 32'd1);
        check("postrst_lo", lo, 32'd0);

        // signed mult of two negatives: -3 * -5 = 15
        issue(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        count_busy(cyc);
        check("negmult_hi", hi, 32'd0);
        check("negmult_lo", lo, 32'd15);

        // 6: madd with hi:lo = 0:1
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd1, 32'd0);
        issue(OP_MADD, 32'd2, 32'd3);
`ifdef XALU_MADD_EN
        check("madd_busy", {31'd0, busy}, 32'd1);
        count_busy(cyc);
        check("madd_lat", cyc, 32'd4 + 32'd1);
        check("madd_lo", lo, 32'd7);
        check("madd_hi", hi, 32'd0);
`else
        check("madd_off_busy", {31'd0, busy}, 32'd0);
        tick();
        check("madd_off_busy2", {31'd0, busy}, 32'd0);
        check("madd_off_lo", lo, 32'd1);
        check("madd_off_hi", hi, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
